// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Drives the data-memory request/ack
// handshake with a bounded wait and registers the MEM/WB bundle.
module mem_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [106:0] exmem,
   input  logic         memAck,
   input  logic [31:0]  memRData,
   output logic         memReq,
   output logic         memWe,
   output logic [31:0]  memAddr,
   output logic [31:0]  memWData,
   output logic         stall,
   output logic         pcSrc,
   output logic [31:0]  branchTarget,
   output logic         memErr,
   output logic [70:0]  out
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   typedef struct packed {
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [31:0] addBranch;
      logic        aluZero;
      logic [31:0] aluResult;
      logic [31:0] readData2;
      logic [4:0]  mw5Out;
   } exmem_t;

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   exmem_t      ex;
   state_t      state;
   state_t      nstate;
   logic [7:0]  cnt;
   logic [31:0] rdata;
   logic        errFlag;
   logic        access;
   logic        start;
   logic        ackDone;
   logic        tmo;

   assign ex = exmem_t'(exmem);
   assign access = ex.m[1] | ex.m[0];
   assign branchTarget = ex.addBranch;
   assign pcSrc = ex.m[2] & ex.aluZero & ~stall & rst;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= nstate;
      end
   end

   always_comb begin
      nstate  = state;
      stall   = 1'b0;
      start   = 1'b0;
      ackDone = 1'b0;
      tmo     = 1'b0;
      memErr  = 1'b0;
      unique case (state)
         IDLE: begin
            stall = access;
            if (access) begin
               start  = 1'b1;
               nstate = ACCESS;
            end
         end
         ACCESS: begin
            stall = 1'b1;
            // a late ack on the final cycle still wins over timeout
            if (memAck && memReq) begin
               ackDone = 1'b1;
               nstate  = DONE;
            end else if (cnt == LAST) begin
               tmo    = 1'b1;
               nstate = DONE;
            end
         end
         DONE: begin
            memErr = errFlag;
            nstate = IDLE;
         end
         default: begin
            nstate = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         memReq   <= 1'b0;
         memWe    <= 1'b0;
         memAddr  <= '0;
         memWData <= '0;
         cnt      <= '0;
         rdata    <= '0;
         errFlag  <= 1'b0;
         out      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  memAddr  <= ex.aluResult;
                  memWData <= ex.readData2;
                  memWe    <= ex.m[0];
                  memReq   <= 1'b1;
                  cnt      <= '0;
                  out      <= '0;
               end else begin
                  out <= {ex.wb, 32'h0,
                          ex.aluResult, ex.mw5Out};
               end
            end
            ACCESS: begin
               // bubble every stalled edge
               out <= '0;
               if (ackDone) begin
                  memReq <= 1'b0;
                  rdata  <= memWe ? 32'h0 : memRData;
               end else if (tmo) begin
                  memReq  <= 1'b0;
                  rdata   <= '0;
                  errFlag <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               out <= {ex.wb, rdata,
                       ex.aluResult, ex.mw5Out};
               errFlag <= 1'b0;
            end
            default: begin
               out <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against
// a transaction-level model of the memory handshake.
module tb_mem_stage;

   localparam int TO = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [106:0] exmem;
   logic         memAck;
   logic [31:0]  memRData;
   logic         memReq;
   logic         memWe;
   logic [31:0]  memAddr;
   logic [31:0]  memWData;
   logic         stall;
   logic         pcSrc;
   logic [31:0]  branchTarget;
   logic         memErr;
   logic [70:0]  out;

   int checks = 0;
   int errors = 0;

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk(clk),
      .rst(rst),
      .exmem(exmem),
      .memAck(memAck),
      .memRData(memRData),
      .memReq(memReq),
      .memWe(memWe),
      .memAddr(memAddr),
      .memWData(memWData),
      .stall(stall),
      .pcSrc(pcSrc),
      .branchTarget(branchTarget),
      .memErr(memErr),
      .out(out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   // One instruction through the stage. ack = ACCESS cycle in which
   // memory answers; 0 or beyond TO means it never answers in time.
   task automatic do_instr(input logic [1:0]  wb,
                           input logic [2:0]  m,
                           input logic [31:0] ab,
                           input logic        z,
                           input logic [31:0] alu,
                           input logic [31:0] rd2,
                           input logic [4:0]  mw,
                           input int          ack,
                           input logic [31:0] rdv);
      logic acc;
      logic err;
      int   last;
      logic [31:0] expRd;
      acc = m[1] | m[0];
      exmem = {wb, m, ab, z, alu, rd2, mw};
      memAck = 1'($urandom);
      memRData = $urandom;
      #1;
      chk("stall_idle", stall, acc);
      chk("pcsrc_idle", pcSrc, m[2] & z & ~acc);
      chk("btarget", branchTarget, ab);
      chk("req_idle", memReq, 1'b0);
      if (!acc) begin
         @(posedge clk);
         @(negedge clk);
         chk("out_alu", out, {wb, 32'h0, alu, mw});
         return;
      end
      err = (ack < 1) || (ack > TO);
      last = err ? TO : ack;
      for (int c = 1; c <= last; c++) begin
         @(posedge clk);
         @(negedge clk);
         memAck = (c == ack);
         memRData = (c == ack) ? rdv : $urandom;
         #1;
         chk("req_acc", memReq, 1'b1);
         chk("we_acc", memWe, m[0]);
         chk("addr_acc", memAddr, alu);
         chk("wdata_acc", memWData, rd2);
         chk("stall_acc", stall, 1'b1);
         chk("pcsrc_acc", pcSrc, 1'b0);
         chk("bubble_acc", out, 71'h0);
         chk("err_acc", memErr, 1'b0);
      end
      @(posedge clk);
      @(negedge clk);
      memAck = 1'($urandom);
      memRData = $urandom;
      #1;
      chk("req_done", memReq, 1'b0);
      chk("stall_done", stall, 1'b0);
      chk("err_done", memErr, err);
      chk("bubble_done", out, 71'h0);
      chk("pcsrc_done", pcSrc, m[2] & z);
      expRd = (err || m[0]) ? 32'h0 : rdv;
      @(posedge clk);
      @(negedge clk);
      chk("out_mem", out, {wb, expRd, alu, mw});
      chk("err_after", memErr, 1'b0);
   endtask

   initial begin
      rst = 1'b0;
      exmem = '0;
      memAck = 1'b0;
      memRData = '0;
      #1;
      chk("rst_req", memReq, 1'b0);
      chk("rst_we", memWe, 1'b0);
      chk("rst_addr", memAddr, 32'h0);
      chk("rst_wdata", memWData, 32'h0);
      chk("rst_err", memErr, 1'b0);
      chk("rst_pcsrc", pcSrc, 1'b0);
      chk("rst_out", out, 71'h0);
      chk("rst_stall", stall, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      do_instr(2'b10, 3'b000, 32'h0, 1'b0, 32'h5,
               32'h0, 5'd3, 0, 32'h0);
      do_instr(2'b11, 3'b010, 32'h0, 1'b0, 32'h100,
               32'h0, 5'd8, 3, 32'hCAFEF00D);
      do_instr(2'b00, 3'b001, 32'h0, 1'b0, 32'h40,
               32'h12345678, 5'd0, 1, 32'hDEADBEEF);
      do_instr(2'b11, 3'b010, 32'h0, 1'b0, 32'h200,
               32'h0, 5'd9, 0, 32'h11111111);
      do_instr(2'b11, 3'b010, 32'h0, 1'b0, 32'h204,
               32'h0, 5'd10, TO, 32'h22222222);
      do_instr(2'b11, 3'b011, 32'h0, 1'b0, 32'h208,
               32'h55AA55AA, 5'd11, 2, 32'h33333333);
      do_instr(2'b00, 3'b100, 32'h80, 1'b1, 32'h0,
               32'h0, 5'd0, 0, 32'h0);
      do_instr(2'b00, 3'b100, 32'h80, 1'b0, 32'h1,
               32'h0, 5'd0, 0, 32'h0);
      do_instr(2'b10, 3'b110, 32'h80, 1'b1, 32'h0,
               32'h0, 5'd4, 2, 32'h44444444);

      // asynchronous reset in the middle of an access
      exmem = {2'b11, 3'b010, 32'h0, 1'b0, 32'h300,
               32'h0, 5'd12};
      memAck = 1'b0;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("req_pre_rst", memReq, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk("req_async_rst", memReq, 1'b0);
      chk("out_async_rst", out, 71'h0);
      chk("stall_in_rst", stall, 1'b1);
      chk("pcsrc_in_rst", pcSrc, 1'b0);
      @(negedge clk);
      exmem = '0;
      rst = 1'b1;
      #1;
      chk("stall_post_rst", stall, 1'b0);
      chk("out_post_rst", out, 71'h0);
      chk("req_post_rst", memReq, 1'b0);
      @(negedge clk);
      chk("out_no_wb", out, {2'b00, 32'h0, 32'h0, 5'd0});

      for (int i = 0; i < 40; i++) begin
         do_instr(2'($urandom), 3'($urandom), $urandom,
                  1'($urandom), $urandom, $urandom,
                  5'($urandom), $urandom_range(0, TO + 1),
                  $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
